// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and default width.
// Intended for reuse by a future serial adder/comparator.
package serial_subtractor_pkg;

  localparam int unsigned DefaultWidth = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bi, bo = borrow out.
// Combinational counterpart of the full_adder cell.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bw_in, LSB first, one bit per clock.
// start/busy/done handshake; result registers update only when entering DONE.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bw_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bw_out
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             bw_q, bw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bw_out_q, bw_out_d;

  logic cell_d;
  logic cell_bo;

  full_subtractor u_cell (
    .a  (sa_q[0]),
    .b  (sb_q[0]),
    .bi (bw_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    bw_d     = bw_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bw_out_d = bw_out_q;

    unique case (state_q)
      StIdle, StDone: begin
        // DONE accepts start just like IDLE so operations can run back-to-back.
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          bw_d    = bw_in;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        sr_d  = {cell_d, sr_q[WIDTH-1:1]};
        bw_d  = cell_bo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = StDone;
          diff_d   = sr_d;
          bw_out_d = cell_bo;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      bw_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bw_out_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      bw_q     <= bw_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bw_out_q <= bw_out_d;
    end
  end

  assign busy   = (state_q == StRun);
  assign done   = (state_q == StDone);
  assign diff   = diff_q;
  assign bw_out = bw_out_q;

endmodule
